// File: rtl/rtc_access_scheduler.sv
// Purpose: schedules RTC bus cycles (address/data phases) for host writes and periodic register-read sweeps.
// Latency: grant to ADDR in 1 clk; a transaction is 2*CYCLE_LEN+2 clk; wr_ack/rd_valid pulse on GAP2 entry.
// Backpressure: wr_req is a level held until wr_ack; one tick queues during a sweep, further ones pulse sweep_overrun.
// Optional: RTC_SCHED_STARVE_GUARD_EN forces a sweep read after two back-to-back writes starve it.
module rtc_access_scheduler #(
    parameter int CYCLE_LEN = 32,
    parameter int N_READ    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       tick,
    input  logic [7:0] sweep_base,
    output logic       sweep_busy,
    output logic       sweep_overrun,
    output logic       EN_signals,
    output logic       read,
    output logic       dato,
    input  logic       ll,
    output logic [7:0] out_byte,
    output logic       out_oe,
    input  logic [7:0] data_in,
    output logic       rd_valid,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_err
);

    localparam logic [5:0] PH_LAST = 6'(CYCLE_LEN - 1);
    localparam logic [4:0] NR      = 5'(N_READ);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;

    state_t     r_state, w_next;
    logic [5:0] r_phase;
    logic       r_op_rd;
    logic [7:0] r_addr, r_data;
    logic       r_ll_prev, r_got;
    logic [7:0] r_cap;
    logic       r_sweep_active, r_tick_pend;
    logic [7:0] r_sweep_base, r_pend_base;
    logic [4:0] r_sweep_idx;

    logic       w_take_wr, w_grant_wr, w_grant_rd;
    logic       w_phase_end, w_enter_gap2, w_rd_pend, w_sweep_done, w_ll_fall;
    logic [7:0] w_sweep_addr;

    assign w_phase_end  = (r_phase == PH_LAST);
    assign w_enter_gap2 = (r_state == DATA) && w_phase_end;
    assign w_rd_pend    = r_sweep_active && (r_sweep_idx < NR);
    assign w_sweep_addr = r_sweep_base + {3'b000, r_sweep_idx};
    assign w_sweep_done = w_enter_gap2 && r_op_rd && (r_sweep_idx == NR);
    assign w_ll_fall    = (r_state == DATA) && r_op_rd && r_ll_prev && !ll;
    assign sweep_busy   = r_sweep_active;

    always_comb begin
        w_next     = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        EN_signals = 1'b0;
        read       = 1'b0;
        dato       = 1'b0;
        out_oe     = 1'b0;
        out_byte   = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_take_wr) begin
                    w_next     = ADDR;
                    w_grant_wr = 1'b1;
                end else if (w_rd_pend) begin
                    w_next     = ADDR;
                    w_grant_rd = 1'b1;
                end
            end
            ADDR: begin
                EN_signals = 1'b1;
                out_oe     = 1'b1;
                out_byte   = r_addr;
                if (w_phase_end) w_next = GAP1;
            end
            GAP1: w_next = DATA;
            DATA: begin
                EN_signals = 1'b1;
                dato       = 1'b1;
                read       = r_op_rd;
                out_oe     = !r_op_rd;
                out_byte   = r_op_rd ? 8'h00 : r_data;
                if (w_phase_end) w_next = GAP2;
            end
            GAP2:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef RTC_SCHED_STARVE_GUARD_EN
    logic [1:0] r_wr_streak;

    assign w_take_wr = wr_req && !(w_rd_pend && (r_wr_streak == 2'd2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_wr_streak <= 2'd0;
        else if (w_grant_rd) r_wr_streak <= 2'd0;
        else if (w_grant_wr) r_wr_streak <= w_rd_pend ? r_wr_streak + 2'd1 : 2'd0;
    end
`else
    assign w_take_wr = wr_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_phase   <= 6'd0;
            r_op_rd   <= 1'b0;
            r_addr    <= 8'h00;
            r_data    <= 8'h00;
            r_ll_prev <= 1'b0;
            r_got     <= 1'b0;
            r_cap     <= 8'h00;
            wr_ack    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= 8'h00;
            rd_data   <= 8'h00;
            rd_err    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_phase   <= ((r_state == ADDR || r_state == DATA) && !w_phase_end) ? r_phase + 6'd1 : 6'd0;
            r_ll_prev <= ll;
            if (w_grant_wr) begin
                r_op_rd <= 1'b0;
                r_addr  <= wr_addr;
                r_data  <= wr_data;
            end else if (w_grant_rd) begin
                r_op_rd <= 1'b1;
                r_addr  <= w_sweep_addr;
                r_data  <= 8'h00;
            end
            if (w_grant_wr || w_grant_rd) begin
                r_got <= 1'b0;
            end else if (w_ll_fall && !r_got) begin
                r_got <= 1'b1;
                r_cap <= data_in;
            end
            wr_ack   <= w_enter_gap2 && !r_op_rd;
            rd_valid <= w_enter_gap2 && r_op_rd;
            // A fall on the final DATA clock is still in flight, so take data_in directly.
            if (w_enter_gap2 && r_op_rd) begin
                rd_addr <= r_addr;
                if (r_got) begin
                    rd_data <= r_cap;
                    rd_err  <= 1'b0;
                end else if (w_ll_fall) begin
                    rd_data <= data_in;
                    rd_err  <= 1'b0;
                end else begin
                    rd_data <= 8'h00;
                    rd_err  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sweep_active <= 1'b0;
            r_sweep_base   <= 8'h00;
            r_sweep_idx    <= 5'd0;
            r_tick_pend    <= 1'b0;
            r_pend_base    <= 8'h00;
            sweep_overrun  <= 1'b0;
        end else begin
            sweep_overrun <= 1'b0;
            if (w_grant_rd) r_sweep_idx <= r_sweep_idx + 5'd1;
            if (w_sweep_done) begin
                if (r_tick_pend) begin
                    r_sweep_base <= r_pend_base;
                    r_sweep_idx  <= 5'd0;
                    r_tick_pend  <= 1'b0;
                end else begin
                    r_sweep_active <= 1'b0;
                end
            end
            // A tick landing on the final read's completion counts against the freed slot.
            if (tick) begin
                if (!r_sweep_active || (w_sweep_done && !r_tick_pend)) begin
                    r_sweep_active <= 1'b1;
                    r_sweep_base   <= sweep_base;
                    r_sweep_idx    <= 5'd0;
                end else if (!r_tick_pend || w_sweep_done) begin
                    r_tick_pend <= 1'b1;
                    r_pend_base <= sweep_base;
                end else begin
                    sweep_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rtc_access_scheduler.md
RTC_ACCESS_SCHEDULER -- requirements
Module: rtc_access_scheduler

Interface
REQ-001 The block SHALL have parameter CYCLE_LEN, default 32, meaning clocks per bus phase (EN_signals high time); legal 4..63.
REQ-002 The block SHALL have parameter N_READ, default 7, meaning registers read per sweep; legal 1..16.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports wr_req  input  1  write request level; wr_addr  input  8  target register; wr_data  input  8  write byte; wr_ack  output  1  one-cycle write-done pulse.
REQ-006 The block SHALL have ports tick  input  1  sweep-start pulse; sweep_base  input  8  first sweep address; sweep_busy  output  1  sweep in progress; sweep_overrun  output  1  one-cycle dropped-tick pulse.
REQ-007 The block SHALL have ports EN_signals  output  1  bus-cycle enable; read  output  1  phase is a read; dato  output  1  0 = address phase, 1 = data phase; ll  input  1  read-latch window from the bus-cycle generator.
REQ-008 The block SHALL have ports out_byte  output  8  byte driven on AD bus; out_oe  output  1  bus drive enable; data_in  input  8  AD bus read-back.
REQ-009 The block SHALL have ports rd_valid  output  1  one-cycle read-result pulse; rd_addr  output  8; rd_data  output  8; rd_err  output  1  read had no ll window.

Function
REQ-010 The FSM SHALL have states IDLE, ADDR, GAP1, DATA, GAP2; one transaction = ADDR, GAP1, DATA, GAP2, then IDLE.
REQ-011 In ADDR and DATA, EN_signals SHALL be 1 for exactly CYCLE_LEN clocks (phase counter 0..CYCLE_LEN-1, 6 bit); GAP1/GAP2 SHALL last exactly 1 clock with EN_signals=0.
REQ-012 ADDR SHALL drive dato=0, read=0, out_oe=1, out_byte=latched address.
REQ-013 DATA SHALL drive dato=1; writes read=0, out_oe=1, out_byte=latched data; reads read=1, out_oe=0, out_byte=0.
REQ-014 In IDLE, GAP1, GAP2 outputs SHALL be EN_signals=0, read=0, dato=0, out_oe=0, out_byte=0.
REQ-015 From IDLE, arbitration SHALL grant a pending write over a pending sweep read; grant moves to ADDR next clock and latches address/data/op at that edge.
REQ-016 Transactions SHALL never be preempted; a write arriving mid-sweep SHALL be served between sweep reads, then the sweep resumes at the next index.
REQ-017 wr_ack SHALL pulse 1 clock on GAP2 entry of a write; wr_req held after wr_ack SHALL start a new write.
REQ-018 tick in IDLE with no sweep SHALL start a sweep: sweep_base latched, reads of base+i for i=0..N_READ-1, address modulo 256 (0xFF wraps to 0x00).
REQ-019 sweep_busy SHALL be 1 from sweep start until GAP2 of its last read.
REQ-020 One tick during a sweep SHALL be stored as pending and start a new sweep immediately after; further ticks while one is pending SHALL be dropped with a sweep_overrun pulse each.
REQ-021 In a read DATA phase, data_in SHALL be captured on the first clock where ll falls (prior 1, now 0); later falls ignored.
REQ-022 On GAP2 entry of a read, rd_valid SHALL pulse 1 clock with rd_addr, rd_data=captured byte, rd_err=0; if no ll fall, rd_data=0, rd_err=1.
REQ-023 rd_addr, rd_data, rd_err SHALL hold until the next rd_valid.

Reset
REQ-024 Reset SHALL force IDLE asynchronously, including mid-transaction; the aborted transaction is neither acked nor reported.
REQ-025 Reset values SHALL be all outputs 0, counters 0, sweep and pending flags clear.

Configuration
REQ-026 With RTC_SCHED_STARVE_GUARD_EN defined, after 2 consecutive write grants while a sweep read is pending, the next grant SHALL go to the sweep read regardless of wr_req.
REQ-027 Without RTC_SCHED_STARVE_GUARD_EN, writes SHALL always win arbitration (REQ-015) and no guard counter SHALL exist.

Verification
REQ-028 wr_req=1, wr_addr=0x21, wr_data=0x5A, CYCLE_LEN=32 -> ADDR 32 clk out_byte=0x21, 1 gap, DATA 32 clk out_byte=0x5A read=0, wr_ack at clock 67 after grant.
REQ-029 tick, sweep_base=0xFE, N_READ=3, ll pulsed each DATA -> reads 0xFE, 0xFF, 0x00; 3 rd_valid pulses, rd_err=0, sweep_busy falls after third.
REQ-030 tick, no ll in DATA -> rd_valid with rd_data=0x00, rd_err=1.
REQ-031 Sweep running, 3 ticks -> one sweep queued, 2 sweep_overrun pulses, second sweep starts right after first.
REQ-032 wr_req held continuously during sweep -> with guard: W,W,R,W,W,R ordering; without guard: sweep stalls until wr_req drops.
REQ-033 reset asserted at phase count 10 of DATA -> EN_signals=0 same cycle, no wr_ack/rd_valid, IDLE after release.
